// File: rtl/shift_piso_tx_if.sv
// Word handshake and serial-side signals of the PISO transmitter.
// The core side uses master; the transmitter uses slave.
interface shift_piso_tx_if #(
  parameter int unsigned WIDTH = 12
);
  logic [WIDTH-1:0] load_data;
  logic             load_valid;
  logic             load_ready;
  logic             shift_out;
  logic             shift_valid;
  logic             last_bit;

  modport master (
    output load_data, load_valid,
    input  load_ready, shift_out, shift_valid, last_bit
  );

  modport slave (
    input  load_data, load_valid,
    output load_ready, shift_out, shift_valid, last_bit
  );
endinterface

// File: rtl/shift_piso_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word over valid/ready
// and shifts it out MSB first, one bit per clk.
module shift_piso_tx #(
  parameter int unsigned WIDTH        = 12,
  parameter bit          BACK_TO_BACK = 1'b1,
  parameter bit          IDLE_BIT     = 1'b0
) (
  input  logic          clk,
  input  logic          clr,
  shift_piso_tx_if.slave bus
);

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sreg_q,  sreg_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic              cnt_last;
  logic              load_ready;
  logic              accept;

  assign cnt_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    cnt_d      = cnt_q;
    load_ready = (state_q == IDLE) ||
                 (BACK_TO_BACK && (state_q == SHIFT) && cnt_last);
    accept     = bus.load_valid && load_ready;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = bus.load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!cnt_last) begin
          sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          cnt_d  = cnt_q + CW'(1);
        end else if (accept) begin
          // Reload on the last bit so the new MSB follows the old LSB with no gap.
          sreg_d = bus.load_data;
          cnt_d  = '0;
        end else begin
          sreg_d  = {sreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.load_ready  = load_ready;
  assign bus.shift_valid = (state_q == SHIFT);
  assign bus.shift_out   = (state_q == SHIFT) ? sreg_q[WIDTH-1] : IDLE_BIT;
  assign bus.last_bit    = (state_q == SHIFT) && cnt_last;

endmodule

// File: tb/tb_shift_piso_tx.sv
// Directed bench for shift_piso_tx: three instances (12-bit back-to-back,
// 12-bit gap mode, 2-bit back-to-back) checked cycle by cycle from a scoreboard.
module tb_shift_piso_tx;

  logic clk;
  logic clr;

  shift_piso_tx_if #(.WIDTH(12)) ia ();
  shift_piso_tx_if #(.WIDTH(12)) ib ();
  shift_piso_tx_if #(.WIDTH(2))  ic ();

  shift_piso_tx #(.WIDTH(12), .BACK_TO_BACK(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk (clk),
    .clr (clr),
    .bus (ia.slave)
  );

  shift_piso_tx #(.WIDTH(12), .BACK_TO_BACK(1'b0), .IDLE_BIT(1'b0)) dut_gap (
    .clk (clk),
    .clr (clr),
    .bus (ib.slave)
  );

  shift_piso_tx #(.WIDTH(2), .BACK_TO_BACK(1'b1), .IDLE_BIT(1'b0)) dut_w2 (
    .clk (clk),
    .clr (clr),
    .bus (ic.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic v;
    logic d;
    logic l;
    logic r;
  } ent_t;

  ent_t        q  [3][$];
  logic [11:0] wq [3][$];
  logic [11:0] sipo [3];
  int unsigned widths [3];

  int unsigned pass_cnt;
  int unsigned total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push_word(input int id, input logic [11:0] data, input bit b2b);
    ent_t e;
    for (int i = 0; i < int'(widths[id]); i++) begin
      e.v = 1'b1;
      e.d = data[int'(widths[id]) - 1 - i];
      e.l = (i == int'(widths[id]) - 1);
      e.r = b2b && e.l;
      q[id].push_back(e);
    end
    wq[id].push_back(data);
  endtask

  task automatic push_idle(input int id);
    ent_t e;
    e.v = 1'b0;
    e.d = 1'b0;
    e.l = 1'b0;
    e.r = 1'b1;
    q[id].push_back(e);
  endtask

  task automatic check_cycle(input int id, input logic v, input logic d,
                             input logic l, input logic r);
    ent_t        e;
    logic [11:0] w;
    logic [11:0] m;
    e.v = 1'b0;
    e.d = 1'b0;
    e.l = 1'b0;
    e.r = 1'b1;
    if (q[id].size() > 0) e = q[id].pop_front();
    chk($sformatf("shift_valid[%0d]", id), 32'(v), 32'(e.v));
    chk($sformatf("shift_out[%0d]", id),   32'(d), 32'(e.d));
    chk($sformatf("last_bit[%0d]", id),    32'(l), 32'(e.l));
    chk($sformatf("load_ready[%0d]", id),  32'(r), 32'(e.r));
    if (v === 1'b1) sipo[id] = {sipo[id][10:0], d};
    if (e.l) begin
      w = 12'hxxx;
      if (wq[id].size() > 0) w = wq[id].pop_front();
      m = (widths[id] >= 12) ? 12'hFFF : ((12'd1 << widths[id]) - 12'd1);
      chk($sformatf("sipo_word[%0d]", id), 32'(sipo[id] & m), 32'(w));
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_cycle(0, ia.shift_valid, ia.shift_out, ia.last_bit, ia.load_ready);
    check_cycle(1, ib.shift_valid, ib.shift_out, ib.last_bit, ib.load_ready);
    check_cycle(2, ic.shift_valid, ic.shift_out, ic.last_bit, ic.load_ready);
  endtask

  initial begin
    pass_cnt  = 0;
    total     = 0;
    widths[0] = 12;
    widths[1] = 12;
    widths[2] = 2;
    for (int i = 0; i < 3; i++) sipo[i] = '0;

    // Reset held with a valid word presented: nothing may be accepted.
    clr           = 1'b1;
    ia.load_data  = 12'hFFF;
    ia.load_valid = 1'b1;
    ib.load_data  = '0;
    ib.load_valid = 1'b0;
    ic.load_data  = '0;
    ic.load_valid = 1'b0;
    @(negedge clk);
    repeat (3) step();
    clr           = 1'b0;
    ia.load_valid = 1'b0;
    step();

    // Single word; load_data changes after accept must not matter.
    ia.load_data  = 12'hA5C;
    ia.load_valid = 1'b1;
    push_word(0, 12'hA5C, 1'b1);
    step();
    ia.load_valid = 1'b0;
    ia.load_data  = 12'h000;
    repeat (13) step();

    // Back-to-back on the default instance: 24 contiguous bits.
    ia.load_data  = 12'h800;
    ia.load_valid = 1'b1;
    push_word(0, 12'h800, 1'b1);
    push_word(0, 12'h001, 1'b1);
    step();
    ia.load_data = 12'h001;
    repeat (11) step();
    step();
    ia.load_valid = 1'b0;
    repeat (13) step();

    // Gap mode: one idle cycle between the same two words.
    ib.load_data  = 12'h800;
    ib.load_valid = 1'b1;
    push_word(1, 12'h800, 1'b0);
    push_idle(1);
    push_word(1, 12'h001, 1'b0);
    step();
    ib.load_data = 12'h001;
    repeat (12) step();
    step();
    ib.load_valid = 1'b0;
    repeat (13) step();

    // Abort during bit 5, then a clean word.
    ia.load_data  = 12'hFFF;
    ia.load_valid = 1'b1;
    push_word(0, 12'hFFF, 1'b1);
    step();
    ia.load_valid = 1'b0;
    repeat (4) step();
    clr = 1'b1;
    q[0].delete();
    wq[0].delete();
    step();
    clr           = 1'b0;
    ia.load_data  = 12'h00F;
    ia.load_valid = 1'b1;
    push_word(0, 12'h00F, 1'b1);
    step();
    ia.load_valid = 1'b0;
    repeat (13) step();

    // Stall: a valid pulse while load_ready is low is ignored.
    ia.load_data  = 12'h3C6;
    ia.load_valid = 1'b1;
    push_word(0, 12'h3C6, 1'b1);
    step();
    ia.load_valid = 1'b0;
    repeat (3) step();
    ia.load_data  = 12'h123;
    ia.load_valid = 1'b1;
    step();
    ia.load_valid = 1'b0;
    ia.load_data  = 12'h000;
    repeat (9) step();

    // WIDTH=2: counter wrap and last_bit on the second cycle.
    ic.load_data  = 2'b10;
    ic.load_valid = 1'b1;
    push_word(2, 12'h002, 1'b1);
    push_word(2, 12'h001, 1'b1);
    step();
    ic.load_data = 2'b01;
    step();
    step();
    ic.load_valid = 1'b0;
    repeat (3) step();

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drain[%0d]", i), 32'(q[i].size()), 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
